// File: rtl/mclk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mclk_pkg
// Description : Shared types and constants for the audio MCLK PLL controller:
//               FSM state encoding, relock counter width/saturation value and
//               helpers for sizing the shared cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
package mclk_pkg;

    // 3-bit state encoding; values 5..7 are unused and recover to HOLD
    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } mclk_state_e;

    localparam int           c_RELOCK_W   = 8;
    localparam logic [c_RELOCK_W-1:0] c_RELOCK_MAX = {c_RELOCK_W{1'b1}};

    // Largest of three cycle limits; the shared counter only has to reach
    // (limit - 1) for whichever phase is longest.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : mclk_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for asynchronous status inputs. Both
//               stages reset to zero so a status bit reads inactive after
//               reset until it has been seen for two clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a full cycle to settle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/mclk_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mclk_pll_ctrl
// Description : Bring-up sequencer for the 11.288888 MHz audio PLL. Pulses the
//               PLL reset, waits for lock, requires a stable lock window before
//               releasing the MCLK-domain reset, retries a bounded number of
//               times and parks in FAULT if lock is never achieved.
// Revision    : 1.0 - initial release
// ============================================================================
module mclk_pll_ctrl
    import mclk_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  restart,
    output logic                  pll_rst,
    output logic                  mclk_rst,
    output logic                  ready,
    output logic                  fault,
    output logic [2:0]            retries,
    output logic [c_RELOCK_W-1:0] relock_count,
    output logic [2:0]            state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_S_HOLD   = ST_HOLD;
    localparam logic [2:0] c_S_WAIT   = ST_WAIT;
    localparam logic [2:0] c_S_SETTLE = ST_SETTLE;
    localparam logic [2:0] c_S_RUN    = ST_RUN;
    localparam logic [2:0] c_S_FAULT  = ST_FAULT;

    // One counter is shared by HOLD, WAIT and SETTLE; it only ever counts up
    // to (limit - 1) of the current phase, so it cannot wrap.
    localparam int c_CNT_MAX = max3(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int c_CNT_W   = cnt_width(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST    = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [2:0]         c_MAX_RETRY    = 3'(MAX_RETRIES);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic                  w_lock_s;
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [2:0]            r_retries;
    logic [2:0]            w_retries_nxt;
    logic [c_RELOCK_W-1:0] r_relock;
    logic [c_RELOCK_W-1:0] w_relock_nxt;
    logic                  w_fail;

    // ------------------------------------------------------------------------
    // Lock indicator comes from the PLL's own clock domain
    // ------------------------------------------------------------------------
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_lock_s)
    );

    // Next-state, counter, retry and relock bookkeeping; restart wins over all
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_retries_nxt = r_retries;
        w_relock_nxt  = r_relock;
        w_fail        = 1'b0;

        case (r_state)
            c_S_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_nxt = c_S_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_S_WAIT: begin
                if (w_lock_s) begin
                    w_state_nxt = c_S_SETTLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_fail = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_S_SETTLE: begin
                if (!w_lock_s) begin
                    w_fail = 1'b1;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_state_nxt   = c_S_RUN;
                    w_cnt_nxt     = '0;
                    w_retries_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            c_S_RUN: begin
                // A lock loss after a good bring-up is not a failed attempt
                if (!w_lock_s) begin
                    w_state_nxt = c_S_HOLD;
                    w_cnt_nxt   = '0;
                    if (r_relock != c_RELOCK_MAX) begin
                        w_relock_nxt = r_relock + c_RELOCK_W'(1);
                    end
                end
            end
            c_S_FAULT: begin
                // Parked until restart or rst
            end
            default: begin
                w_state_nxt = c_S_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_fail) begin
            w_cnt_nxt = '0;
            if (r_retries == c_MAX_RETRY) begin
                w_state_nxt = c_S_FAULT;
            end else begin
                w_state_nxt   = c_S_HOLD;
                w_retries_nxt = r_retries + 3'd1;
            end
        end

        if (restart) begin
            w_state_nxt   = c_S_HOLD;
            w_cnt_nxt     = '0;
            w_retries_nxt = '0;
        end
    end

    // State and counter registers
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_HOLD;
            r_cnt     <= '0;
            r_retries <= '0;
            r_relock  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retries <= w_retries_nxt;
            r_relock  <= w_relock_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs; unused encodings keep the PLL and MCLK domain in reset
    // ------------------------------------------------------------------------
    assign pll_rst      = !((r_state == c_S_WAIT) || (r_state == c_S_SETTLE) ||
                            (r_state == c_S_RUN));
    assign ready        = (r_state == c_S_RUN);
    assign mclk_rst     = (r_state != c_S_RUN);
    assign fault        = (r_state == c_S_FAULT);
    assign retries      = r_retries;
    assign relock_count = r_relock;
    assign state        = r_state;

endmodule : mclk_pll_ctrl
`default_nettype wire

// File: tb/tb_mclk_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mclk_pll_ctrl
// Description : Self-checking bench for mclk_pll_ctrl with HOLD=4, TIMEOUT=32,
//               STABLE=8, MAX_RETRIES=2. Table of input/expected records plus
//               hand-written relock-saturation and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mclk_pll_ctrl;

    localparam logic [2:0] HOLD   = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] FAULT  = 3'd4;

    typedef struct {
        logic       rst;
        logic       locked;
        logic       restart;
        int         cycles;
        logic [2:0] st;
        logic       rdy;
        logic       prst;
        logic       mrst;
        logic       flt;
        logic [2:0] ret;
        logic [7:0] rc;
        string      name;
    } vec_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       mclk_rst;
    logic       ready;
    logic       fault;
    logic [2:0] retries;
    logic [7:0] relock_count;
    logic [2:0] state;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    mclk_pll_ctrl #(
        .HOLD_CYCLES   (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .restart      (restart),
        .pll_rst      (pll_rst),
        .mclk_rst     (mclk_rst),
        .ready        (ready),
        .fault        (fault),
        .retries      (retries),
        .relock_count (relock_count),
        .state        (state)
    );

    always #5 refclk = ~refclk;

    function automatic vec_t mk(input logic r, input logic l, input logic rs,
                                input int c, input logic [2:0] s,
                                input logic [2:0] rt, input logic [7:0] rc,
                                input string nm);
        vec_t v;
        v.rst = r; v.locked = l; v.restart = rs; v.cycles = c;
        v.st = s; v.ret = rt; v.rc = rc; v.name = nm;
        // Output decode expected by state name
        v.rdy  = (s == RUN);
        v.mrst = (s != RUN);
        v.prst = (s == HOLD) || (s == FAULT);
        v.flt  = (s == FAULT);
        return v;
    endfunction

    task automatic check_head();
        vec_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: no expected record queued");
        end else begin
            e = exp_q.pop_front();
            if (state !== e.st || ready !== e.rdy || pll_rst !== e.prst ||
                mclk_rst !== e.mrst || fault !== e.flt || retries !== e.ret ||
                relock_count !== e.rc) begin
                n_bad++;
                $display("FAIL %s: got st=%0d rdy=%b prst=%b mrst=%b flt=%b ret=%0d rc=%0d, want st=%0d rdy=%b prst=%b mrst=%b flt=%b ret=%0d rc=%0d",
                         e.name, state, ready, pll_rst, mclk_rst, fault, retries,
                         relock_count, e.st, e.rdy, e.prst, e.mrst, e.flt, e.ret, e.rc);
            end
        end
    endtask

    // Drive a record's inputs, queue its expectation, clock it, compare mid-cycle
    task automatic run_vec(input vec_t v);
        rst        = v.rst;
        pll_locked = v.locked;
        restart    = v.restart;
        exp_q.push_back(v);
        repeat (v.cycles) @(posedge refclk);
        @(negedge refclk);
        check_head();
    endtask

    initial begin
        // Reset, bring-up with late lock, loss in RUN
        tbl.push_back(mk(1, 0, 0,  2, HOLD,   0, 0, "reset_state"));
        tbl.push_back(mk(0, 0, 0,  3, HOLD,   0, 0, "hold_3_cycles"));
        tbl.push_back(mk(0, 0, 0,  1, WAIT,   0, 0, "hold_ends_at_4"));
        tbl.push_back(mk(0, 0, 0,  6, WAIT,   0, 0, "wait_no_lock"));
        tbl.push_back(mk(0, 1, 0,  2, WAIT,   0, 0, "sync_latency"));
        tbl.push_back(mk(0, 1, 0,  1, SETTLE, 0, 0, "enter_settle"));
        tbl.push_back(mk(0, 1, 0,  7, SETTLE, 0, 0, "settle_edge10"));
        tbl.push_back(mk(0, 1, 0,  1, RUN,    0, 0, "run_at_edge11"));
        tbl.push_back(mk(0, 0, 0,  2, RUN,    0, 0, "loss_edge2"));
        tbl.push_back(mk(0, 0, 0,  1, HOLD,   0, 1, "loss_edge3"));
        // Lock never arrives: three attempts then FAULT
        tbl.push_back(mk(0, 0, 0,  4, WAIT,   0, 1, "try0_wait"));
        tbl.push_back(mk(0, 0, 0, 31, WAIT,   0, 1, "try0_timeout_m1"));
        tbl.push_back(mk(0, 0, 0,  1, HOLD,   1, 1, "try0_fail"));
        tbl.push_back(mk(0, 0, 0, 36, HOLD,   2, 1, "try1_fail"));
        tbl.push_back(mk(0, 0, 0, 36, FAULT,  2, 1, "try2_fault"));
        tbl.push_back(mk(0, 0, 0, 50, FAULT,  2, 1, "fault_sticky"));
        // Restart out of FAULT
        tbl.push_back(mk(0, 0, 1,  1, HOLD,   0, 1, "restart_fault"));
        tbl.push_back(mk(0, 0, 0,  4, WAIT,   0, 1, "restart_hold"));
        // Lock lost during SETTLE, then good re-lock
        tbl.push_back(mk(0, 1, 0,  3, SETTLE, 0, 1, "settle_entry"));
        tbl.push_back(mk(0, 1, 0,  4, SETTLE, 0, 1, "settle_cnt4"));
        tbl.push_back(mk(0, 0, 0,  2, SETTLE, 0, 1, "settle_drop"));
        tbl.push_back(mk(0, 0, 0,  1, HOLD,   1, 1, "settle_fail"));
        tbl.push_back(mk(0, 1, 0,  4, WAIT,   1, 1, "relock_hold"));
        tbl.push_back(mk(0, 1, 0,  1, SETTLE, 1, 1, "relock_settle"));
        tbl.push_back(mk(0, 1, 0,  7, SETTLE, 1, 1, "relock_settle7"));
        tbl.push_back(mk(0, 1, 0,  1, RUN,    0, 1, "relock_run"));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // 256 more losses: counter climbs from 1 and pins at 255
        for (int i = 0; i < 256; i++) begin
            int rc_exp;
            rc_exp = (i + 2 > 255) ? 255 : i + 2;
            run_vec(mk(0, 0, 0,  3, HOLD, 0, 8'(rc_exp), "sat_loss"));
            run_vec(mk(0, 1, 0, 13, RUN,  0, 8'(rc_exp), "sat_relock"));
        end

        // Async reset mid-SETTLE, checked before the next clock edge
        run_vec(mk(0, 0, 0, 3, HOLD,   0, 255, "pre_rst_loss"));
        run_vec(mk(0, 1, 0, 8, SETTLE, 0, 255, "pre_rst_settle"));
        rst = 1'b1;
        exp_q.push_back(mk(1, 1, 0, 0, HOLD, 0, 0, "async_rst"));
        #1;
        check_head();
        @(negedge refclk);
        // Release with lock already high, then restart out of RUN
        run_vec(mk(0, 1, 0, 4, WAIT,   0, 0, "post_rst_hold"));
        run_vec(mk(0, 1, 0, 1, SETTLE, 0, 0, "post_rst_settle"));
        run_vec(mk(0, 1, 0, 8, RUN,    0, 0, "post_rst_run"));
        run_vec(mk(0, 1, 1, 1, HOLD,   0, 0, "restart_run"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_mclk_pll_ctrl
`default_nettype wire

// File: doc/mclk_pll_ctrl.md
MCLK_PLL_CTRL -- requirements
Module: mclk_pll_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1).
REQ-002 Parameter LOCK_TIMEOUT, 50000, cycles allowed in WAIT for lock (1 ms at 50 MHz).
REQ-003 Parameter STABLE_CYCLES, 1024, consecutive locked cycles required before RUN.
REQ-004 Parameter MAX_RETRIES, 7, failed attempts tolerated before FAULT.
REQ-005 Ports shall be exactly as follows (clock and reset first); the block has one clock, refclk, and reset rst is asynchronous and active-high.
- refclk  in  1  50 MHz reference clock; the PLL reference and the only clock of this block.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indicator; asynchronous to refclk.
- restart  in  1  single-cycle soft re-initialisation request.
- pll_rst  out  1  reset to the 11.288888 MHz audio PLL.
- mclk_rst  out  1  reset for the MCLK domain, high until the clock is stable; the consumer resynchronises it.
- ready  out  1  MCLK valid.
- fault  out  1  lock never achieved within MAX_RETRIES+1 attempts.
- retries  out  3  attempts failed since the last success or restart.
- relock_count  out  8  lock losses seen in RUN; saturates at 255.
- state  out  3  current FSM state encoding.

Function
REQ-006 pll_locked shall pass through a 2-flop synchronizer (flops reset to 0) whose output is lock_s; only lock_s is used internally.
REQ-007 States shall be HOLD, WAIT, SETTLE, RUN and FAULT; all outputs shall be Moore outputs decoded from the registered state and counters.
REQ-008 HOLD: pll_rst=1; the shared counter increments each cycle; when the counter equals HOLD_CYCLES-1 the FSM moves to WAIT and the counter clears.
REQ-009 WAIT: pll_rst=0.
- lock_s=1: go to SETTLE and clear the counter.
- Otherwise, when the counter equals LOCK_TIMEOUT-1, take the failure path (REQ-011).
REQ-010 SETTLE: pll_rst=0.
- lock_s=0: take the failure path (REQ-011).
- When the counter equals STABLE_CYCLES-1: go to RUN and clear retries.
REQ-011 Failure path:
- If retries==MAX_RETRIES, go to FAULT.
- Otherwise increment retries, go to HOLD and clear the counter.
REQ-012 RUN: ready=1, mclk_rst=0, pll_rst=0; on lock_s=0, go to HOLD, clear the counter and increment relock_count (saturating at 255); retries is not incremented.
REQ-013 FAULT: pll_rst=1, fault=1, mclk_rst=1; FAULT is left only via restart or rst.
REQ-014 mclk_rst shall be high and ready low in every state except RUN.
REQ-015 restart=1 in any state shall force HOLD, clear the counter and clear retries next cycle; restart has priority over all other transitions; relock_count is unchanged.
REQ-016 Latency: with pll_locked first sampled high at edge 1 while in WAIT and held high, ready and the mclk_rst fall shall occur at edge STABLE_CYCLES+3.
REQ-017 Loss latency: pll_locked falling before edge 1 while in RUN shall drop ready and raise mclk_rst at edge 3.
REQ-018 The counter shall be sized to max(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) and shall never wrap.

Reset
REQ-019 While rst=1, outputs shall immediately take these values, including mid-operation: state=HOLD, counter=0, retries=0, relock_count=0, synchronizer=0, pll_rst=1, mclk_rst=1, ready=0, fault=0.
REQ-020 After rst falls, the first HOLD shall last exactly HOLD_CYCLES cycles.

Structure
REQ-021 Package mclk_pkg shall hold the state enum (3-bit encoding), the relock_count width and the saturation constant.
REQ-022 The synchronizer shall be sub-module sync_2ff, reused for other asynchronous status inputs.

Verification (all scenarios use HOLD_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-023 Release rst, raise pll_locked 10 cycles later -> pll_rst high 4 cycles after reset; ready=1 and mclk_rst=0 at edge 11 after first high sample; retries=0.
REQ-024 pll_locked tied low -> three HOLD(4)/WAIT(32) attempts, retries 0->1->2, then FAULT: fault=1, pll_rst=1 held indefinitely.
REQ-025 In SETTLE, drop pll_locked for 3 cycles at counter=5 -> HOLD, retries=1, ready never asserts; on re-lock, RUN is reached with retries=0.
REQ-026 In RUN, drop pll_locked -> ready=0 at edge 3, relock_count=1, state=HOLD; 256 repeated losses -> relock_count stays 255.
REQ-027 restart pulse in FAULT -> HOLD next cycle, fault=0, retries=0.
REQ-028 rst asserted mid-SETTLE -> all outputs at their reset values without waiting for a refclk edge.
